aes_key_sched_seq: RTL and testbench

Iterative AES key-expansion engine that produces one 32-bit schedule word per clock and stores the full round-key set in an internal word buffer. It sits directly upstream of the cipher/inverse-cipher datapath. That datapath indexes round keys through a read port instead of holding a fully unrolled combinational expansion. Supports AES-128/192/256, selected by parameter.

---
 rtl/aes_key_sched_seq_if.sv | 15 +
 rtl/aes_key_sched_seq.sv | 196 +++++++++++++++++++
 tb/tb_aes_key_sched_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_seq_if.sv
// Handshake and read-port bundle for the iterative AES key-schedule engine.
// The master drives start/key_in/rk_idx, and the slave (the engine) returns status and round keys.
interface aes_key_sched_seq_if #(
  parameter int NK = 4
);
  logic                start;
  logic [32*NK-1:0]    key_in;
  logic                busy;
  logic                key_ready;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_out;

  modport master (output start, key_in, rk_idx, input busy, key_ready, rk_out);
  modport slave  (input start, key_in, rk_idx, output busy, key_ready, rk_out);
endinterface

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock into a word buffer.
// Optional macro AES_KS_REVERSE_ORDER_EN maps rk_idx to round NR-rk_idx on the read port.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2_s, x3_s, x12_s, x14_s, x15_s, x240_s, inv_s;

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform
  always_comb begin
    x2_s   = gf_mul(in_i, in_i);
    x3_s   = gf_mul(x2_s, in_i);
    x12_s  = gf_mul(gf_mul(x3_s, x3_s), gf_mul(x3_s, x3_s));
    x14_s  = gf_mul(x12_s, x2_s);
    x15_s  = gf_mul(x12_s, x3_s);
    x240_s = gf_mul(x15_s, x15_s);
    x240_s = gf_mul(x240_s, x240_s);
    x240_s = gf_mul(x240_s, x240_s);
    x240_s = gf_mul(x240_s, x240_s);
    inv_s  = gf_mul(x240_s, x14_s);
    out_o  = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_sched_seq #(
  parameter int NK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_sched_seq_if.slave bus
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_READY  = 2'd3;
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [2:0] DN_TOP   = 3'(NK - 1);
  localparam logic [3:0] NR_W     = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2:0]       dn_q, dn_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             busy_q, busy_d, ready_q, ready_d;
  logic [32*NK-1:0] key_q, key_d;
  logic [31:0]      w_q [NW];

  logic        accept_s, sub_only_s;
  logic [31:0] w_prev_s, w_far_s, rot_s, sub_in_s, sub_s, temp_s;
  logic [3:0]  rk_sel_s;
  logic [5:0]  base_s;

  assign accept_s   = bus.start && ((state_q == S_IDLE) || (state_q == S_READY));
  assign w_prev_s   = w_q[cnt_q - 6'd1];
  assign w_far_s    = w_q[cnt_q - NK_W];
  assign rot_s      = {w_prev_s[23:0], w_prev_s[31:24]};
  // dn_q counts down to 0 at every multiple of NK, so dn_q==4 marks i mod 8 == 4 for AES-256
  assign sub_only_s = (NK == 8) && (dn_q == 3'd4);
  assign sub_in_s   = sub_only_s ? w_prev_s : rot_s;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.in_i(sub_in_s[8*g +: 8]), .out_o(sub_s[8*g +: 8]));
  end

  // Select the temp word mixed into w[i-NK]
  always_comb begin
    temp_s = w_prev_s;
    if (dn_q == 3'd0)    temp_s = sub_s ^ {rcon_q, 24'h000000};
    else if (sub_only_s) temp_s = sub_s;
    else                 temp_s = w_prev_s;
  end

  // FSM and counter next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dn_d    = dn_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (accept_s) begin
          key_d   = bus.key_in;
          state_d = S_LOAD;
          ready_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        cnt_d   = NK_W;
        dn_d    = 3'd0;
        rcon_d  = 8'h01;
        busy_d  = 1'b1;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        cnt_d = cnt_q + 6'd1;
        if (dn_q == 3'd0) begin
          dn_d   = DN_TOP;
          rcon_d = xtime(rcon_q);
        end else begin
          dn_d = dn_q - 3'd1;
        end
        if (cnt_q == LAST_W) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          state_d = S_EXPAND;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      dn_q    <= 3'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      key_q   <= key_d;
    end
  end

  // Schedule word buffer; contents are masked on the read port until key_ready
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= key_q[32*(NK-1-k) +: 32];
      end
    end else if (state_q == S_EXPAND) begin
      w_q[cnt_q] <= w_far_s ^ temp_s;
    end else begin
      w_q[0] <= w_q[0];
    end
  end

`ifdef AES_KS_REVERSE_ORDER_EN
  assign rk_sel_s = NR_W - bus.rk_idx;
`else
  assign rk_sel_s = bus.rk_idx;
`endif
  assign base_s = {rk_sel_s, 2'b00};

  // Round-key read port
  always_comb begin
    if (ready_q && (bus.rk_idx <= NR_W)) begin
      bus.rk_out = {w_q[base_s], w_q[base_s + 6'd1], w_q[base_s + 6'd2], w_q[base_s + 6'd3]};
    end else begin
      bus.rk_out = 128'h0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_ready = ready_q;
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench: three engines (AES-128/192/256) against a table-driven FIPS-197 key-expansion model.
module tb_aes_key_sched_seq;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic [31:0] mw [60];

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_t [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [255:0] KEY1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched_seq_if #(.NK(4)) if4 ();
  aes_key_sched_seq_if #(.NK(6)) if6 ();
  aes_key_sched_seq_if #(.NK(8)) if8 ();

  aes_key_sched_seq #(.NK(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  aes_key_sched_seq #(.NK(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6));
  aes_key_sched_seq #(.NK(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_start(input int nk, input logic v);
    case (nk)
      4: if4.start = v;
      6: if6.start = v;
      default: if8.start = v;
    endcase
  endtask

  task automatic set_key(input int nk, input logic [255:0] k);
    case (nk)
      4: if4.key_in = k[127:0];
      6: if6.key_in = k[191:0];
      default: if8.key_in = k;
    endcase
  endtask

  task automatic set_idx(input int nk, input int idx);
    case (nk)
      4: if4.rk_idx = 4'(idx);
      6: if6.rk_idx = 4'(idx);
      default: if8.rk_idx = 4'(idx);
    endcase
  endtask

  function automatic logic get_busy(input int nk);
    case (nk)
      4: return if4.busy;
      6: return if6.busy;
      default: return if8.busy;
    endcase
  endfunction

  function automatic logic get_ready(input int nk);
    case (nk)
      4: return if4.key_ready;
      6: return if6.key_ready;
      default: return if8.key_ready;
    endcase
  endfunction

  function automatic logic [127:0] get_rk(input int nk);
    case (nk)
      4: return if4.rk_out;
      6: return if6.rk_out;
      default: return if8.rk_out;
    endcase
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion written directly from the standard's pseudocode
  task automatic model_expand(input int nk, input logic [255:0] key);
    int nw;
    logic [31:0] t;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) mw[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h000000};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // Port index that should expose logical round r
  function automatic int port_idx(input int nk, input int r);
`ifdef AES_KS_REVERSE_ORDER_EN
    return nk + 6 - r;
`else
    return r;
`endif
  endfunction

  function automatic logic [127:0] exp_rk(input int nk, input int idx);
    int r;
    if (idx > nk + 6) return 128'h0;
    r = port_idx(nk, idx);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic pulse_start(input int nk, input logic [255:0] key);
    @(negedge clk);
    set_key(nk, key);
    set_start(nk, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(nk, 1'b0);
  endtask

  // Start an expansion and check busy/key_ready on every cycle up to key_ready
  task automatic run_expand(input int nk, input logic [255:0] key, input bit inj, input logic [255:0] inj_key);
    int lat;
    lat = 1 + 4 * (nk + 7) - nk;
    pulse_start(nk, key);
    n_total++;
    if (get_busy(nk) !== 1'b0 || get_ready(nk) !== 1'b0 || get_rk(nk) !== 128'h0) begin
      $display("FAIL edge0 nk=%0d: busy=%b ready=%b rk=%h, required 0/0/0", nk, get_busy(nk), get_ready(nk), get_rk(nk));
    end else n_pass++;
    for (int k = 1; k <= lat; k++) begin
      if (inj && k == 10) begin
        set_key(nk, inj_key);
        set_start(nk, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      if (inj && k == 10) set_start(nk, 1'b0);
      n_total++;
      if (get_busy(nk) !== (k < lat) || get_ready(nk) !== (k == lat)) begin
        $display("FAIL timing nk=%0d edge=%0d: busy=%b ready=%b, required busy=%b ready=%b",
                 nk, k, get_busy(nk), get_ready(nk), k < lat, k == lat);
      end else n_pass++;
    end
  endtask

  task automatic check_all(input int nk);
    for (int i = 0; i < 16; i++) begin
      set_idx(nk, i);
      #1;
      n_total++;
      if (get_rk(nk) !== exp_rk(nk, i)) begin
        $display("FAIL rk nk=%0d idx=%0d: got %h, required %h", nk, i, get_rk(nk), exp_rk(nk, i));
      end else n_pass++;
    end
  endtask

  task automatic check_round(input int nk, input int r, input logic [127:0] want, input string name);
    set_idx(nk, port_idx(nk, r));
    #1;
    n_total++;
    if (get_rk(nk) !== want) $display("FAIL %s: got %h, required %h", name, get_rk(nk), want);
    else n_pass++;
  endtask

  task automatic test_reset;
    for (int j = 0; j < 3; j++) begin
      int nk;
      nk = 4 + 2 * j;
      set_idx(nk, 0);
      #1;
      n_total++;
      if (get_busy(nk) !== 1'b0 || get_ready(nk) !== 1'b0 || get_rk(nk) !== 128'h0) begin
        $display("FAIL reset nk=%0d: busy=%b ready=%b rk=%h, required 0/0/0", nk, get_busy(nk), get_ready(nk), get_rk(nk));
      end else n_pass++;
    end
  endtask

  task automatic test_vectors;
    model_expand(4, KEY1);
    run_expand(4, KEY1, 1'b0, '0);
    check_round(4, 1, 128'ha0fafe1788542cb123a339392a6c7605, "aes128_r1");
    check_round(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_r10");
    check_all(4);
    model_expand(8, KEY8);
    run_expand(8, KEY8, 1'b0, '0);
    check_round(8, 14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_r14");
    check_all(8);
  endtask

  task automatic test_busy_restart;
    model_expand(4, KEY1);
    run_expand(4, KEY1, 1'b1, {$urandom, $urandom, $urandom, $urandom, 128'h0});
    check_round(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ignored_start_r10");
    check_all(4);
    model_expand(4, 256'h0);
    run_expand(4, 256'h0, 1'b0, '0);
    check_round(4, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_key_r10");
    check_all(4);
  endtask

  task automatic test_abort;
    pulse_start(4, KEY1);
    repeat (20) @(posedge clk);
    #1;
    n_total++;
    if (get_busy(4) !== 1'b1) $display("FAIL busy_before_abort: got %b, required 1", get_busy(4));
    else n_pass++;
    #1 rst_n = 1'b0;
    set_idx(4, 1);
    #1;
    n_total++;
    if (get_busy(4) !== 1'b0 || get_ready(4) !== 1'b0 || get_rk(4) !== 128'h0) begin
      $display("FAIL abort: busy=%b ready=%b rk=%h, required 0/0/0", get_busy(4), get_ready(4), get_rk(4));
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_expand(4, KEY1);
    run_expand(4, KEY1, 1'b0, '0);
    check_round(4, 1, 128'ha0fafe1788542cb123a339392a6c7605, "after_abort_r1");
    check_all(4);
  endtask

  task automatic test_random;
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 0; j < 3; j++) begin
        int nk;
        logic [255:0] key;
        nk  = 4 + 2 * j;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (nk == 4) key[255:128] = '0;
        else if (nk == 6) key[255:192] = '0;
        else key = key;
        model_expand(nk, key);
        run_expand(nk, key, 1'b0, '0);
        check_all(nk);
      end
    end
  endtask

`ifdef AES_KS_REVERSE_ORDER_EN
  task automatic test_reverse;
    model_expand(4, KEY1);
    run_expand(4, KEY1, 1'b0, '0);
    set_idx(4, 0);
    #1;
    n_total++;
    if (if4.rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL rev_idx0: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", if4.rk_out);
    else n_pass++;
    set_idx(4, 10);
    #1;
    n_total++;
    if (if4.rk_out !== 128'h2b7e151628aed2a6abf7158809cf4f3c) $display("FAIL rev_idx10: got %h, required 2b7e151628aed2a6abf7158809cf4f3c", if4.rk_out);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    if4.start = 1'b0; if4.key_in = '0; if4.rk_idx = 4'd0;
    if6.start = 1'b0; if6.key_in = '0; if6.rk_idx = 4'd0;
    if8.start = 1'b0; if8.key_in = '0; if8.rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_vectors;
    test_busy_restart;
    test_abort;
    test_random;
`ifdef AES_KS_REVERSE_ORDER_EN
    test_reverse;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
